// File: rtl/nvdla_mcif_rd_responder.sv
`default_nettype none
// ============================================================================
// Module      : nvdla_mcif_rd_responder
// Description : Memory-side read responder for the SDP RDMA read channel.
//               Queues 47-bit read requests (byte address + beats-1), fetches
//               64-bit atoms from a synchronous single-port backing memory and
//               returns them in request order as 65-bit response beats.
// Ports       : nvdla_core_clk / nvdla_core_rst   clock, async active-high reset
//               rd_req_pd/valid/ready             request channel ([31:0] addr,
//                                                 [46:32] size = beats-1)
//               rd_rsp_pd/valid/ready             response channel ([63:0]
//                                                 data, [64] mask)
//               mem_rd_en/addr/data               backing memory read port
//                                                 (data 1 cycle after en)
//               err_oob                           sticky out-of-range flag
//               busy                              any work pending
// Revision    : 1.0 - initial release
// ============================================================================
module nvdla_mcif_rd_responder #(
    parameter int MEM_AW    = 16,
    parameter int REQ_DEPTH = 4
) (
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rst,
    input  logic [46:0]       rd_req_pd,
    input  logic              rd_req_valid,
    output logic              rd_req_ready,
    output logic [64:0]       rd_rsp_pd,
    output logic              rd_rsp_valid,
    input  logic              rd_rsp_ready,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [63:0]       mem_rd_data,
    output logic              err_oob,
    output logic              busy
);

    localparam int                 C_PTR_W = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
    localparam logic [C_PTR_W:0]   C_DEPTH = (C_PTR_W + 1)'(REQ_DEPTH);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    // ------------------------------------------------------------------
    // Request FIFO
    // ------------------------------------------------------------------
    logic [46:0]        r_fifo_mem [REQ_DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_PTR_W:0]   r_fifo_cnt;
    logic               r_rdy_en;
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_empty;
    logic               w_fifo_full;

    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_fifo_full  = (r_fifo_cnt == C_DEPTH);
    // r_rdy_en holds ready low while reset is asserted without routing the
    // reset net into the datapath.
    assign rd_req_ready = r_rdy_en & ~w_fifo_full;
    assign w_push       = rd_req_valid & rd_req_ready;

    always_ff @(posedge nvdla_core_clk) begin
        if (w_push) begin
            r_fifo_mem[r_wr_ptr] <= rd_req_pd;
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_fifo_cnt <= '0;
            r_rdy_en   <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_fifo_cnt <= r_fifo_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_fifo_cnt <= r_fifo_cnt - 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO head decode
    // ------------------------------------------------------------------
    logic [46:0]       w_head;
    logic [MEM_AW-1:0] w_head_base;
    logic [14:0]       w_head_size;
    logic              w_head_oob;
    logic              w_unused_head;

    assign w_head        = r_fifo_mem[r_rd_ptr];
    assign w_head_base   = w_head[MEM_AW+2:3];
    assign w_head_size   = w_head[46:32];
    assign w_unused_head = ^w_head[2:0];

    generate
        if (MEM_AW < 29) begin : g_oob_chk
            assign w_head_oob = |w_head[31:MEM_AW+3];
        end else begin : g_no_oob
            assign w_head_oob = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Issue permission: output buffer (2 entries) plus one read in flight.
    // ------------------------------------------------------------------
    logic [1:0] r_buf_cnt;
    logic       r_inflight;
    logic       r_inflight_oob;
    logic       w_acc;
    logic [2:0] w_occ;
    logic       w_perm;

    assign w_acc  = rd_rsp_valid & rd_rsp_ready;
    assign w_occ  = {1'b0, r_buf_cnt} + {2'b00, r_inflight};
    assign w_perm = (w_occ <= ({2'b00, w_acc} + 3'd1));

    // ------------------------------------------------------------------
    // Burst engine
    // ------------------------------------------------------------------
    logic [0:0]        r_state;
    logic [MEM_AW-1:0] r_base;
    logic [14:0]       r_size;
    logic [14:0]       r_beat_idx;
    logic              r_oob;
    logic              r_err_oob;

    logic              w_issue;
    logic [MEM_AW-1:0] w_cur_addr;
    logic              w_cur_oob;
    logic              w_cur_last;

    // In IDLE the head entry is issued directly so beat 0 goes to memory the
    // cycle after the request lands; the request is popped (and loaded)
    // even when issue is stalled, so the engine always holds one request.
    always_comb begin
        w_issue    = 1'b0;
        w_pop      = 1'b0;
        w_cur_addr = w_head_base;
        w_cur_oob  = w_head_oob;
        w_cur_last = (w_head_size == 15'd0);
        if (r_state == S_IDLE) begin
            w_pop   = ~w_fifo_empty;
            w_issue = ~w_fifo_empty & w_perm;
        end else begin
            w_cur_addr = r_base + MEM_AW'(r_beat_idx);
            w_cur_oob  = r_oob;
            w_cur_last = (r_beat_idx == r_size);
            w_issue    = w_perm;
            w_pop      = w_perm & w_cur_last & ~w_fifo_empty;
        end
    end

    // Out-of-range beats consume a slot but never strobe the memory.
    assign mem_rd_en   = w_issue & ~w_cur_oob;
    assign mem_rd_addr = mem_rd_en ? w_cur_addr : '0;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_state        <= S_IDLE;
            r_base         <= '0;
            r_size         <= '0;
            r_beat_idx     <= '0;
            r_oob          <= 1'b0;
            r_err_oob      <= 1'b0;
            r_inflight     <= 1'b0;
            r_inflight_oob <= 1'b0;
        end else begin
            r_inflight     <= w_issue;
            r_inflight_oob <= w_issue & w_cur_oob;
            if (w_pop && w_head_oob) begin
                r_err_oob <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_base <= w_head_base;
                        r_size <= w_head_size;
                        r_oob  <= w_head_oob;
                        if (w_issue) begin
                            r_beat_idx <= 15'd1;
                            r_state    <= (w_head_size == 15'd0) ? S_IDLE : S_BURST;
                        end else begin
                            r_beat_idx <= 15'd0;
                            r_state    <= S_BURST;
                        end
                    end
                end
                default: begin
                    if (w_issue) begin
                        if (w_cur_last) begin
                            if (!w_fifo_empty) begin
                                r_base     <= w_head_base;
                                r_size     <= w_head_size;
                                r_oob      <= w_head_oob;
                                r_beat_idx <= 15'd0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_beat_idx <= r_beat_idx + 15'd1;
                        end
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output buffer. The read in flight is logically the entry behind the
    // buffer; when the buffer is empty it is presented straight from the
    // memory's registered output so beat 0 appears two cycles after the
    // request handshake. An unaccepted in-flight beat is captured into the
    // buffer, so the presented data stays stable.
    // ------------------------------------------------------------------
    logic [63:0] r_buf [2];
    logic        r_buf_wr;
    logic        r_buf_rd;
    logic [63:0] w_inf_data;
    logic [63:0] w_out_data;
    logic        w_buf_push;
    logic        w_buf_pop;

    assign w_inf_data = r_inflight_oob ? 64'h0 : mem_rd_data;
    assign w_buf_pop  = w_acc & (r_buf_cnt != 2'd0);
    assign w_buf_push = r_inflight & ~(w_acc & (r_buf_cnt == 2'd0));
    assign w_out_data = (r_buf_cnt != 2'd0) ? r_buf[r_buf_rd] : w_inf_data;

    assign rd_rsp_valid = (r_buf_cnt != 2'd0) | r_inflight;
    assign rd_rsp_pd    = rd_rsp_valid ? {1'b1, w_out_data} : 65'h0;

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            r_buf[0]  <= '0;
            r_buf[1]  <= '0;
            r_buf_wr  <= 1'b0;
            r_buf_rd  <= 1'b0;
            r_buf_cnt <= '0;
        end else begin
            if (w_buf_push) begin
                r_buf[r_buf_wr] <= w_inf_data;
                r_buf_wr        <= ~r_buf_wr;
            end
            if (w_buf_pop) begin
                r_buf_rd <= ~r_buf_rd;
            end
            if (w_buf_push && !w_buf_pop) begin
                r_buf_cnt <= r_buf_cnt + 2'd1;
            end else if (w_buf_pop && !w_buf_push) begin
                r_buf_cnt <= r_buf_cnt - 2'd1;
            end
        end
    end

    assign err_oob = r_err_oob;
    assign busy    = ~w_fifo_empty | (r_state == S_BURST) | r_inflight | (r_buf_cnt != 2'd0);

endmodule
`default_nettype wire
